led_share_sequencer: RTL and testbench
======================================

// Module: led_share_sequencer
// PURPOSE
//  Shares the 8-bit LED display among N_REQ requesters. Each requester asks for the
//  display with a 2-bit pattern mode. Ownership is granted round-robin for a bounded
//  number of prescaled ticks. The block sits between the user-control logic and the
//  board LED pins, and it sequences the pattern shown while a requester holds the grant.
// PARAMETERS
//  N_REQ       4  number of requesters (2..8)
//  PRESCALE    4  enabled CLK cycles per pattern tick (>=2)
//  HOLD_TICKS  8  ticks a grant lasts before forced release (1..255)
// PORTS
//  CLK       in   1        system clock, rising edge
//  RST       in   1        asynchronous, active-low reset
//  enable    in   1        1 = prescaler/hold counting runs; 0 = freeze
//  req       in   N_REQ    level request, bit i = requester i
//  req_mode  in   2*N_REQ  mode of requester i at [2i+1:2i]
//  gnt       out  N_REQ    one-hot grant, registered
//  busy      out  1        1 while state != IDLE
//  done      out  N_REQ    1-cycle pulse to the owner on release
//  led       out  8        registered LED pattern
// BEHAVIOUR
//  Reset (RST=0, async): state=IDLE, gnt=0, busy=0, done=0, led=8'h00, rr_ptr=0,
//   prescaler=0, hold_cnt=0.
//  FSM states: IDLE -> RUN -> RELEASE -> IDLE.
//  IDLE
//   - If enable && |req, at the edge: grant the first set req at or after rr_ptr
//     (modulo N_REQ); go to RUN.
//   - Latch mode_q from the winner's req_mode; prescaler=0, hold_cnt=0; led=initial pattern.
//   - Grant latency: req sampled high at edge k -> gnt valid after edge k.
//   - enable=0 or req=0: stay in IDLE, all outputs hold reset values.
//  RUN
//   - tick = enable && prescaler==PRESCALE-1. The prescaler wraps to 0 on a tick and
//     holds while enable=0.
//   - On each tick, hold_cnt++. If hold_cnt reaches HOLD_TICKS, go to RELEASE; otherwise
//     led steps per mode.
//   - If the owner's req is 0 at an edge, go to RELEASE (early release). This is
//     independent of enable, and takes precedence over a tick on the same edge.
//   - req_mode changes during RUN are ignored; mode_q is fixed per grant.
//  Modes (sized literals; case carries a default that gives OFF):
//   2'b00 COUNT: init 8'h00, +1 per tick, 8'hFF wraps to 8'h00
//   2'b01 WALK : init 8'h01, rotate-left per tick, 8'h80 -> 8'h01
//   2'b10 OFF  : 8'h00 constant
//   2'b11 ON   : 8'hFF constant
//  RELEASE (exactly 1 cycle)
//   - gnt=0, led=8'h00, done[owner]=1, rr_ptr=owner+1 (wraps N_REQ-1 -> 0); next IDLE.
//   - A re-grant is possible at the edge after the RELEASE cycle. The owner just
//     released has lowest priority.
//  Boundaries
//   - Simultaneous requests: lowest index at/after rr_ptr wins.
//   - A req bit rising during RUN waits; there is no preemption.
//   - Full-length grant = HOLD_TICKS*PRESCALE enabled cycles in RUN.
//   - RST asserted mid-RUN: immediate return to reset values. No done pulse.
//  Widths: prescaler $clog2(PRESCALE); hold_cnt 8 bits; rr_ptr $clog2(N_REQ).
//  Index arithmetic wraps explicitly with a compare against N_REQ-1; never truncates.
// STRUCTURE
//  Package led_ctrl_pkg:
//   - MODE_COUNT/MODE_WALK/MODE_OFF/MODE_ON = 2'b00/01/10/11
//   - state encodings ST_IDLE/ST_RUN/ST_RELEASE
//   - LED_W=8
//  Sub-module led_tick_gen (prescaler: CLK, RST, enable, clear -> tick).
//  Arbiter and pattern logic stay in this module.
// TESTING
//  1. Reset: hold RST=0 with req=4'hF -> gnt=0, busy=0, done=0, led=8'h00.
//  2. req=4'b0001, mode0=2'b01, enable=1 -> gnt=4'b0001 after 1 edge; led 01,02,04,..,80
//     every 4 cycles; after 32 RUN cycles 1-cycle RELEASE with done=4'b0001, led=00.
//  3. req=4'hF constant, all mode 2'b00 -> grants in order 0001,0010,0100,1000,0001;
//     each led counts 00..07.
//  4. Owner drops req after 5 cycles -> RELEASE next edge, done pulse, next requester
//     granted after 1 IDLE edge.
//  5. enable=0 for 10 cycles mid-RUN -> led, prescaler and hold_cnt frozen; gnt held;
//     total RUN = 32+10 cycles.
//  6. RST pulse low mid-RUN (mode 2'b11, led=FF) -> led=00, gnt=0 immediately; done
//     never pulses.

Source files
------------

// File: rtl/led_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// | Package : led_ctrl_pkg                                                    |
// | Shared LED width, pattern modes, FSM encodings and pattern helpers.       |
// | Revision: 1.0                                                             |
// ---------------------------------------------------------------------------
`default_nettype none

package led_ctrl_pkg;

  localparam int LED_W = 8;

  localparam logic [1:0] MODE_COUNT = 2'b00;
  localparam logic [1:0] MODE_WALK  = 2'b01;
  localparam logic [1:0] MODE_OFF   = 2'b10;
  localparam logic [1:0] MODE_ON    = 2'b11;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  function automatic logic [LED_W-1:0] led_init(input logic [1:0] mode);
    case (mode)
      MODE_COUNT: led_init = 8'h00;
      MODE_WALK:  led_init = 8'h01;
      MODE_ON:    led_init = 8'hFF;
      default:    led_init = 8'h00;
    endcase
  endfunction

  function automatic logic [LED_W-1:0] led_step(input logic [1:0]       mode,
                                                input logic [LED_W-1:0] cur);
    case (mode)
      MODE_COUNT: led_step = cur + 8'd1;
      MODE_WALK:  led_step = {cur[LED_W-2:0], cur[LED_W-1]};
      MODE_ON:    led_step = 8'hFF;
      default:    led_step = 8'h00;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/led_tick_gen.sv
// ---------------------------------------------------------------------------
// | Module  : led_tick_gen                                                    |
// | Prescaler producing one tick every PRESCALE enabled cycles.               |
// | Revision: 1.0                                                             |
// ---------------------------------------------------------------------------
`default_nettype none

module led_tick_gen #(
  parameter int PRESCALE = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = $clog2(PRESCALE);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick = enable && !clear && (cnt_q == CNT_W'(PRESCALE - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

`default_nettype wire

// File: rtl/led_share_sequencer.sv
// ---------------------------------------------------------------------------
// | Module  : led_share_sequencer                                             |
// | Round-robin sharing of the LED display with per-grant pattern sequencing. |
// | Revision: 1.0                                                             |
// ---------------------------------------------------------------------------
`default_nettype none

module led_share_sequencer
  import led_ctrl_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int PRESCALE   = 4,
  parameter int HOLD_TICKS = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               enable,
  input  logic [N_REQ-1:0]   req,
  input  logic [2*N_REQ-1:0] req_mode,
  output logic [N_REQ-1:0]   gnt,
  output logic               busy,
  output logic [N_REQ-1:0]   done,
  output logic [LED_W-1:0]   led
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [1:0]       state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic [LED_W-1:0] led_q, led_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [1:0]       mode_q, mode_d;
  logic [7:0]       hold_q, hold_d;

  logic             tick;
  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W:0]   scan_idx;
  logic [1:0]       win_mode;
  logic [IDX_W-1:0] owner_next;

  led_tick_gen #(.PRESCALE(PRESCALE)) u_tick (
    .CLK    (CLK),
    .RST    (RST),
    .enable (enable),
    .clear  (state_q != ST_RUN),
    .tick   (tick)
  );

  // Scan starts at rr_ptr; the extra index bit keeps the wrap compare exact.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      scan_idx = {1'b0, rr_ptr_q} + (IDX_W+1)'(i);
      if (scan_idx > (IDX_W+1)'(N_REQ - 1)) scan_idx = scan_idx - (IDX_W+1)'(N_REQ);
      if (!win_found && req[scan_idx[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = scan_idx[IDX_W-1:0];
      end
    end
  end

  assign win_mode   = req_mode[{win_idx, 1'b0} +: 2];
  assign owner_next = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    done_d   = '0;
    led_d    = led_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    mode_d   = mode_q;
    hold_d   = hold_q;
    case (state_q)
      ST_IDLE: begin
        if (enable && win_found) begin
          state_d = ST_RUN;
          gnt_d   = N_REQ'(1) << win_idx;
          owner_d = win_idx;
          mode_d  = win_mode;
          hold_d  = 8'd0;
          led_d   = led_init(win_mode);
        end
      end
      ST_RUN: begin
        // Owner dropping its request wins over a coincident tick.
        if (!req[owner_q] || (tick && (hold_q + 8'd1 == 8'(HOLD_TICKS)))) begin
          state_d  = ST_RELEASE;
          gnt_d    = '0;
          led_d    = '0;
          done_d   = gnt_q;
          rr_ptr_d = owner_next;
        end else if (tick) begin
          hold_d = hold_q + 8'd1;
          led_d  = led_step(mode_q, led_q);
        end
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
        hold_d  = 8'd0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= ST_IDLE;
      gnt_q    <= '0;
      done_q   <= '0;
      led_q    <= '0;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      mode_q   <= MODE_COUNT;
      hold_q   <= 8'd0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      led_q    <= led_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      mode_q   <= mode_d;
      hold_q   <= hold_d;
    end
  end

  assign gnt  = gnt_q;
  assign done = done_q;
  assign led  = led_q;
  assign busy = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_led_share_sequencer.sv
// ---------------------------------------------------------------------------
// | Module  : tb_led_share_sequencer                                          |
// | Directed self-checking bench for led_share_sequencer.                     |
// | Revision: 1.0                                                             |
// ---------------------------------------------------------------------------
`default_nettype none

module tb_led_share_sequencer;

  logic       CLK;
  logic       RST;
  logic       enable;
  logic [3:0] req;
  logic [7:0] req_mode;
  logic [3:0] gnt;
  logic       busy;
  logic [3:0] done;
  logic [7:0] led;

  int total;
  int bad;

  led_share_sequencer #(
    .N_REQ      (4),
    .PRESCALE   (4),
    .HOLD_TICKS (8)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .enable   (enable),
    .req      (req),
    .req_mode (req_mode),
    .gnt      (gnt),
    .busy     (busy),
    .done     (done),
    .led      (led)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [3:0] g_exp;
    total = 0;
    bad   = 0;

    // 1. reset held with all requests asserted
    RST = 1'b0; enable = 1'b1; req = 4'hF; req_mode = 8'h00;
    step(3);
    chk("rst_gnt",  gnt,  4'b0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 4'b0000);
    chk("rst_led",  led,  8'h00);
    req = 4'h0;
    RST = 1'b1;
    step(1);
    chk("idle_noreq_gnt", gnt, 4'b0000);

    // 2. single requester, WALK mode, full-length grant
    req = 4'b0001; req_mode = 8'b0000_0001;
    step(1);
    chk("walk_gnt",  gnt,  4'b0001);
    chk("walk_busy", busy, 1'b1);
    chk("walk_led0", led,  8'h01);
    for (int j = 1; j < 8; j++) begin
      step(4);
      chk("walk_led", led, 8'h01 << j);
    end
    step(4);
    chk("walk_rel_gnt",  gnt,  4'b0000);
    chk("walk_rel_done", done, 4'b0001);
    chk("walk_rel_led",  led,  8'h00);
    chk("walk_rel_busy", busy, 1'b1);
    req = 4'h0;
    step(1);
    chk("walk_idle_done", done, 4'b0000);
    chk("walk_idle_busy", busy, 1'b0);

    // 3. all requesting in COUNT mode from a fresh rr pointer
    RST = 1'b0;
    step(1);
    RST = 1'b1; req = 4'hF; req_mode = 8'h00;
    for (int k = 0; k < 5; k++) begin
      g_exp = 4'b0001 << (k % 4);
      step(1);
      chk("rr_gnt",  gnt, g_exp);
      chk("rr_led0", led, 8'h00);
      step(28);
      chk("rr_led7", led, 8'h07);
      step(4);
      chk("rr_done", done, g_exp);
      chk("rr_rel_gnt", gnt, 4'b0000);
      step(1);
      chk("rr_idle_busy", busy, 1'b0);
    end
    req = 4'h0;

    // 4. early release; rr pointer now at 1
    req = 4'b0110; req_mode = 8'b00_01_11_00;
    step(1);
    chk("early_gnt", gnt, 4'b0010);
    chk("early_led", led, 8'hFF);
    step(5);
    chk("early_led_on", led, 8'hFF);
    req = 4'b0100;
    step(1);
    chk("early_done", done, 4'b0010);
    chk("early_rel_gnt", gnt, 4'b0000);
    step(1);
    chk("early_idle_gnt", gnt, 4'b0000);
    step(1);
    chk("early_next_gnt", gnt, 4'b0100);
    chk("early_next_led", led, 8'h01);

    // 5. enable freeze mid-RUN
    step(4);
    chk("frz_led_a", led, 8'h02);
    step(2);
    enable = 1'b0;
    step(10);
    chk("frz_led_hold", led, 8'h02);
    chk("frz_gnt_hold", gnt, 4'b0100);
    chk("frz_busy",     busy, 1'b1);
    enable = 1'b1;
    step(2);
    chk("frz_led_b", led, 8'h04);
    step(20);
    chk("frz_led_end", led, 8'h80);
    step(3);
    chk("frz_gnt_late", gnt, 4'b0100);
    step(1);
    chk("frz_done", done, 4'b0100);
    req = 4'h0;
    step(1);

    // 6. async reset mid-RUN; rr pointer now at 3
    req = 4'b1000; req_mode = 8'b11_00_00_00;
    step(1);
    chk("rst_run_gnt", gnt, 4'b1000);
    chk("rst_run_led", led, 8'hFF);
    step(3);
    RST = 1'b0;
    #2;
    chk("async_led",  led,  8'h00);
    chk("async_gnt",  gnt,  4'b0000);
    chk("async_busy", busy, 1'b0);
    chk("async_done", done, 4'b0000);
    req = 4'h0;
    step(1);
    RST = 1'b1;
    step(2);
    chk("post_rst_done", done, 4'b0000);
    chk("post_rst_gnt",  gnt,  4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
